// File: rtl/crack_disp_pkg.sv
// crack_disp_pkg: shared types and segment constants for the crack engine display controller.
`default_nettype none

package crack_disp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_SHOW      = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    DISP_BLANK = 2'd0,
    DISP_DASH  = 2'd1,
    DISP_E     = 2'd2,
    DISP_FONT  = 2'd3
  } disp_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;

endpackage

`default_nettype wire

// File: rtl/crack_disp_ctrl_if.sv
// crack_disp_ctrl_if: en/rdy launch handshake and key result from one crack engine.
`default_nettype none

interface crack_disp_ctrl_if #(
  parameter int KEY_W = 24
);
  logic             en;
  logic             rdy;
  logic [KEY_W-1:0] key_in;
  logic             key_valid_in;

  modport master (output en, input rdy, input key_in, input key_valid_in);
  modport slave  (input en, output rdy, output key_in, output key_valid_in);
endinterface

`default_nettype wire

// File: rtl/crack_disp_ctrl_hex7seg.sv
// hex7seg: combinational nibble to active-low 7-segment pattern (bits g..a).
`default_nettype none

module hex7seg (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    case (nibble_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/crack_disp_ctrl.sv
// crack_disp_ctrl: launches/supervises a crack engine and shows its result on hex digits.
// Optional run-length counter and display enabled by defining CRACK_CYCLE_COUNT_EN.
`default_nettype none

module crack_disp_ctrl
  import crack_disp_pkg::*;
#(
  parameter int KEY_W      = 24,
  parameter int NUM_DIGITS = 6,
  parameter int START_TO   = 1024,
  parameter bit AUTO_START = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    show_cycles,
  crack_disp_ctrl_if.master       eng,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic                    busy,
  output logic                    done,
  output logic                    found,
  output logic                    timeout,
  output logic [31:0]             cycles
);

  localparam int DISP_W = 4 * NUM_DIGITS;
  localparam int TO_W   = (START_TO > 1) ? $clog2(START_TO) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TO - 1);

  state_t                  state_q, state_d;
  logic                    en_q, en_d;
  logic                    auto_q;
  logic [TO_W-1:0]         to_q;
  logic [KEY_W-1:0]        key_q;
  logic                    valid_q;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  disp_t                   disp_mode;
  logic [DISP_W-1:0]       disp_val;
  logic [7*NUM_DIGITS-1:0] font_w;
  logic                    show_cyc_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (start || auto_q) state_d = ST_LAUNCH;
      ST_LAUNCH:    if (eng.rdy) state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (!eng.rdy)            state_d = ST_WAIT_DONE;
        else if (to_q == TO_LAST) state_d = ST_FAULT;
      end
      ST_WAIT_DONE: if (eng.rdy) state_d = ST_SHOW;
      ST_SHOW:      if (start) state_d = ST_LAUNCH;
      ST_FAULT:     if (start) state_d = ST_LAUNCH;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    en_d      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    found     = 1'b0;
    timeout   = 1'b0;
    disp_mode = DISP_BLANK;
    case (state_q)
      ST_LAUNCH:    en_d = eng.rdy;
      ST_WAIT_BUSY: busy = 1'b1;
      ST_WAIT_DONE: busy = 1'b1;
      ST_SHOW: begin
        done  = 1'b1;
        found = valid_q;
        disp_mode = (valid_q || show_cyc_w) ? DISP_FONT : DISP_DASH;
      end
      ST_FAULT: begin
        timeout   = 1'b1;
        disp_mode = DISP_E;
      end
      default: ;
    endcase
  end

  // The timeout window starts at the launch cycle; the result is latched on the rdy rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q    <= 1'b0;
      auto_q  <= AUTO_START;
      to_q    <= '0;
      key_q   <= '0;
      valid_q <= 1'b0;
      hex_q   <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      en_q  <= en_d;
      hex_q <= hex_d;
      if (state_q == ST_LAUNCH && eng.rdy) begin
        auto_q <= 1'b0;
        to_q   <= '0;
      end else if (state_q == ST_WAIT_BUSY) begin
        to_q <= to_q + 1'b1;
      end
      if (state_q == ST_WAIT_DONE && eng.rdy) begin
        key_q   <= eng.key_in;
        valid_q <= eng.key_valid_in;
      end
    end
  end

`ifdef CRACK_CYCLE_COUNT_EN
  logic [31:0] cycles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles_q <= '0;
    end else if (state_q == ST_LAUNCH) begin
      cycles_q <= '0;
    end else if ((state_q == ST_WAIT_BUSY || state_q == ST_WAIT_DONE) && cycles_q != 32'hFFFF_FFFF) begin
      cycles_q <= cycles_q + 32'd1;
    end
  end

  assign cycles     = cycles_q;
  assign show_cyc_w = show_cycles;
`else
  logic unused_show_cycles;
  assign unused_show_cycles = show_cycles;
  assign cycles     = '0;
  assign show_cyc_w = 1'b0;
`endif

  assign disp_val = (state_q == ST_SHOW && show_cyc_w) ? DISP_W'(cycles) : DISP_W'(key_q);

  generate
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      hex7seg u_hex7seg (
        .nibble_i (disp_val[4*g +: 4]),
        .seg_o    (font_w[7*g +: 7])
      );
      assign hex_d[7*g +: 7] = (disp_mode == DISP_FONT) ? font_w[7*g +: 7] :
                               (disp_mode == DISP_DASH) ? SEG_DASH :
                               (disp_mode == DISP_E)    ? SEG_E    : SEG_BLANK;
    end
  endgenerate

  assign hex    = hex_q;
  assign eng.en = en_q;

endmodule

`default_nettype wire

// File: tb/tb_crack_disp_ctrl.sv
// tb_crack_disp_ctrl: scenario tasks with a behavioural engine and display model.
`default_nettype none

module tb_crack_disp_ctrl;

  localparam int KW  = 24;
  localparam int ND  = 6;
  localparam int STO = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            show_cycles;
  logic [7*ND-1:0] hex;
  logic            busy, done, found, timeout;
  logic [31:0]     cycles;

  int checks   = 0;
  int failures = 0;

  logic [6:0] font_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  crack_disp_ctrl_if #(.KEY_W(KW)) eng_if ();

  crack_disp_ctrl #(
    .KEY_W      (KW),
    .NUM_DIGITS (ND),
    .START_TO   (STO),
    .AUTO_START (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .show_cycles (show_cycles),
    .eng         (eng_if),
    .hex         (hex),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .timeout     (timeout),
    .cycles      (cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [7*ND-1:0] all_digits(input logic [6:0] seg);
    logic [7*ND-1:0] r;
    for (int i = 0; i < ND; i++) r[7*i +: 7] = seg;
    return r;
  endfunction

  // Expected SHOW display from the result, found flag and run length.
  function automatic logic [7*ND-1:0] exp_show(input logic [KW-1:0] k, input logic v,
                                               input logic sc, input int ncyc);
    logic [7*ND-1:0] r;
    longint unsigned val;
    bit use_font;
    val = k;
    use_font = v;
`ifdef CRACK_CYCLE_COUNT_EN
    if (sc) begin
      val = longint'(ncyc);
      use_font = 1'b1;
    end
`endif
    for (int i = 0; i < ND; i++)
      r[7*i +: 7] = use_font ? font_tab[(val >> (4*i)) % 16] : 7'h3F;
    return r;
  endfunction

  function automatic int exp_cycles(input int ncyc);
`ifdef CRACK_CYCLE_COUNT_EN
    return ncyc;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_en(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (eng_if.en === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called in the cycle en is seen; returns in the first SHOW cycle.
  task automatic do_run(input int drop, input int low, input logic [KW-1:0] k, input logic v,
                        input bit mid_start, output int ncyc, output int en_cnt);
    ncyc   = 0;
    en_cnt = 1;
    repeat (drop) begin
      ncyc++;
      tick();
      if (eng_if.en === 1'b1) en_cnt++;
    end
    eng_if.rdy    = 1'b0;
    eng_if.key_in = KW'($urandom);
    for (int i = 0; i < low; i++) begin
      if (mid_start && i == low / 2) start = 1'b1;
      ncyc++;
      tick();
      start = 1'b0;
      if (eng_if.en === 1'b1) en_cnt++;
    end
    eng_if.rdy          = 1'b1;
    eng_if.key_in       = k;
    eng_if.key_valid_in = v;
    ncyc++;
    tick();
    if (eng_if.en === 1'b1) en_cnt++;
    eng_if.key_in       = ~k;
    eng_if.key_valid_in = ~v;
  endtask

  task automatic test_reset();
    bit ok;
    rst_n = 1'b0;
    start = 1'b0;
    show_cycles = 1'b0;
    eng_if.rdy = 1'b1;
    eng_if.key_in = '0;
    eng_if.key_valid_in = 1'b0;
    tick();
    tick();
    checks++;
    if ({eng_if.en, busy, done, found, timeout} !== 5'b0 || cycles !== 32'd0 || hex !== all_digits(7'h7F)) begin
      failures++;
      $display("FAIL reset_state: en/busy/done/found/timeout=%b cycles=%0d hex=%h, need 0/0 and hex %h",
               {eng_if.en, busy, done, found, timeout}, cycles, hex, all_digits(7'h7F));
    end
    rst_n = 1'b1;
    wait_en(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL auto_start_en: no en within 8 cycles of reset release, need one pulse");
    end
  endtask

  task automatic test_auto_result();
    int ncyc, en_cnt;
    logic [7*ND-1:0] want;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_in_run: busy=%b need 1", busy);
    end
    do_run(0, 50, 24'h1A2B3C, 1'b1, 1'b0, ncyc, en_cnt);
    ncyc++;
    en_cnt = en_cnt;
    checks++;
    if (en_cnt !== 1 || done !== 1'b1 || found !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL first_result_flags: en_pulses=%0d done=%b found=%b busy=%b need 1/1/1/0",
               en_cnt, done, found, busy);
    end
    checks++;
    if (hex !== all_digits(7'h7F)) begin
      failures++;
      $display("FAIL display_lag: hex=%h need blank %h one cycle after entering result", hex, all_digits(7'h7F));
    end
    tick();
    want = {7'h79, 7'h08, 7'h24, 7'h03, 7'h30, 7'h46};
    checks++;
    if (hex !== want) begin
      failures++;
      $display("FAIL key_display: hex=%h need %h", hex, want);
    end
    checks++;
    if (cycles !== 32'(exp_cycles(ncyc))) begin
      failures++;
      $display("FAIL run_cycles: cycles=%0d need %0d", cycles, exp_cycles(ncyc));
    end
    show_cycles = 1'b1;
    tick();
    want = exp_show(24'h1A2B3C, 1'b1, 1'b1, ncyc);
    checks++;
    if (hex !== want) begin
      failures++;
      $display("FAIL cycles_display: hex=%h need %h", hex, want);
    end
    show_cycles = 1'b0;
    tick();
  endtask

  task automatic test_not_found();
    bit ok;
    int ncyc, en_cnt;
    pulse_start();
    wait_en(ok);
    checks++;
    if (!ok || done !== 1'b0 || hex !== all_digits(7'h7F)) begin
      failures++;
      $display("FAIL relaunch_from_show: en_seen=%b done=%b hex=%h need 1/0/blank", ok, done, hex);
    end
    do_run(3, 20, KW'($urandom), 1'b0, 1'b0, ncyc, en_cnt);
    tick();
    checks++;
    if (found !== 1'b0 || done !== 1'b1 || hex !== all_digits(7'h3F)) begin
      failures++;
      $display("FAIL not_found: found=%b done=%b hex=%h need 0/1/%h", found, done, hex, all_digits(7'h3F));
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    int ncyc, en_cnt;
    logic [KW-1:0] k;
    pulse_start();
    wait_en(ok);
    k = KW'($urandom);
    do_run(2, 12, k, 1'b1, 1'b1, ncyc, en_cnt);
    checks++;
    if (!ok || en_cnt !== 1) begin
      failures++;
      $display("FAIL start_in_wait: en_seen=%b en_pulses=%0d need 1/1", ok, en_cnt);
    end
    tick();
    pulse_start();
    tick();
    checks++;
    if (hex !== all_digits(7'h7F) || eng_if.en !== 1'b1) begin
      failures++;
      $display("FAIL show_to_launch: hex=%h en=%b need blank/1", hex, eng_if.en);
    end
    k = KW'($urandom);
    do_run(1, 7, k, 1'b1, 1'b0, ncyc, en_cnt);
    tick();
    checks++;
    if (hex !== exp_show(k, 1'b1, 1'b0, ncyc)) begin
      failures++;
      $display("FAIL second_key: hex=%h need %h", hex, exp_show(k, 1'b1, 1'b0, ncyc));
    end
  endtask

  task automatic test_timeout();
    bit ok, early;
    int ncyc, en_cnt;
    early = 1'b0;
    pulse_start();
    wait_en(ok);
    for (int i = 1; i < STO; i++) begin
      tick();
      if (timeout !== 1'b0 || busy !== 1'b1) early = 1'b1;
    end
    checks++;
    if (!ok || early) begin
      failures++;
      $display("FAIL timeout_early: en_seen=%b early_fault=%b need 1/0", ok, early);
    end
    tick();
    checks++;
    if (timeout !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_at_limit: timeout=%b busy=%b need 1/0 after %0d cycles", timeout, busy, STO);
    end
    tick();
    checks++;
    if (hex !== all_digits(7'h06)) begin
      failures++;
      $display("FAIL fault_display: hex=%h need %h", hex, all_digits(7'h06));
    end
    pulse_start();
    wait_en(ok);
    checks++;
    if (!ok || timeout !== 1'b0) begin
      failures++;
      $display("FAIL fault_relaunch: en_seen=%b timeout=%b need 1/0", ok, timeout);
    end
    do_run(2, 5, KW'($urandom), 1'b1, 1'b0, ncyc, en_cnt);
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int ncyc, en_cnt;
    pulse_start();
    wait_en(ok);
    tick();
    eng_if.rdy = 1'b0;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({eng_if.en, busy, done, found, timeout} !== 5'b0 || cycles !== 32'd0 || hex !== all_digits(7'h7F)) begin
      failures++;
      $display("FAIL async_reset: en/busy/done/found/timeout=%b cycles=%0d hex=%h need zeros/blank",
               {eng_if.en, busy, done, found, timeout}, cycles, hex);
    end
    eng_if.rdy = 1'b1;
    tick();
    rst_n = 1'b1;
    wait_en(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL reset_relaunch: no en within 8 cycles of release, need auto relaunch");
    end
    do_run(1, 4, KW'($urandom), 1'b1, 1'b0, ncyc, en_cnt);
  endtask

  task automatic test_random();
    bit ok;
    int ncyc, en_cnt, drop, low;
    logic [KW-1:0] k;
    logic v, sc;
    for (int it = 0; it < 10; it++) begin
      k    = KW'($urandom);
      v    = 1'($urandom_range(0, 1));
      sc   = 1'($urandom_range(0, 1));
      drop = $urandom_range(1, 10);
      low  = $urandom_range(1, 40);
      pulse_start();
      wait_en(ok);
      show_cycles = sc;
      do_run(drop - 1, low, k, v, 1'($urandom_range(0, 1)), ncyc, en_cnt);
      tick();
      checks++;
      if (!ok || en_cnt !== 1 || done !== 1'b1 || found !== v || cycles !== 32'(exp_cycles(ncyc + 1))
          || hex !== exp_show(k, v, sc, ncyc + 1)) begin
        failures++;
        $display("FAIL random_run[%0d]: en=%0d done=%b found=%b cycles=%0d hex=%h need 1/1/%b/%0d/%h",
                 it, en_cnt, done, found, cycles, hex, v, exp_cycles(ncyc + 1), exp_show(k, v, sc, ncyc + 1));
      end
    end
    show_cycles = 1'b0;
  endtask

  initial begin
    test_reset();
    test_auto_result();
    test_not_found();
    test_start_ignored();
    test_timeout();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
